// File: rtl/mem_access_seq.sv
// Single-transaction RAM sequencer (fetch / load / store) for the multicycle datapath.
// Optional MOC timeout detection is enabled by defining MEM_TIMEOUT_EN.
module mem_access_seq #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic       Clk,
   input  logic       Clr,
   input  logic       req,
   input  logic [1:0] kind,
   input  logic       MOC,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       MuxMAR_Sel,
   output logic       MAR_Ld,
   output logic       MuxMDR_Sel,
   output logic       MDR_Ld,
   output logic       IR_Ld,
   output logic       MOV,
   output logic       RW,
   output logic [2:0] state_out
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ADDR    = 3'd1,
      S_ACCESS  = 3'd2,
      S_CAPTURE = 3'd3,
      S_RELEASE = 3'd4,
      S_DONE    = 3'd5,
      S_ERR     = 3'd6
   } state_t;

   localparam logic [1:0] K_FETCH = 2'b00;
   localparam logic [1:0] K_LOAD  = 2'b01;
   localparam logic [1:0] K_STORE = 2'b10;
   localparam logic [1:0] K_ILL   = 2'b11;

   generate
      if (TIMEOUT < 1 || TIMEOUT >= (1 << CNT_W)) begin : g_bad_params
         $error("mem_access_seq: CNT_W too narrow for TIMEOUT");
      end
   endgenerate

   state_t           state_q, state_d;
   logic [1:0]       kind_q, kind_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;

   // Wait counter saturates instead of wrapping.
   assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

`ifdef MEM_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
   logic err_q, err_d;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         state_q <= S_IDLE;
         kind_q  <= K_FETCH;
         cnt_q   <= '0;
`ifdef MEM_TIMEOUT_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         cnt_q   <= cnt_d;
`ifdef MEM_TIMEOUT_EN
         err_q   <= err_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      kind_d     = kind_q;
      cnt_d      = cnt_q;
`ifdef MEM_TIMEOUT_EN
      err_d      = err_q;
`endif
      busy       = (state_q != S_IDLE);
      done       = 1'b0;
      MuxMAR_Sel = 1'b0;
      MAR_Ld     = 1'b0;
      MuxMDR_Sel = 1'b0;
      MDR_Ld     = 1'b0;
      IR_Ld      = 1'b0;
      MOV        = 1'b0;
      RW         = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (req && kind != K_ILL) begin
               kind_d  = kind;
               state_d = S_ADDR;
`ifdef MEM_TIMEOUT_EN
               err_d   = 1'b0;
`endif
            end
         end
         S_ADDR: begin
            MAR_Ld     = 1'b1;
            MuxMAR_Sel = (kind_q != K_FETCH);
            MDR_Ld     = (kind_q == K_STORE);
            cnt_d      = '0;
            state_d    = S_ACCESS;
         end
         S_ACCESS: begin
            MOV   = 1'b1;
            RW    = (kind_q != K_STORE);
            cnt_d = cnt_inc;
            if (MOC) begin
               state_d = S_CAPTURE;
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt_q == TMO_LAST) begin
               state_d = S_ERR;
               err_d   = 1'b1;
            end
`endif
         end
         S_CAPTURE: begin
            // MOV/RW held so the RAM keeps driving DataOut while it is captured.
            MOV        = 1'b1;
            RW         = (kind_q != K_STORE);
            IR_Ld      = (kind_q == K_FETCH);
            MDR_Ld     = (kind_q == K_LOAD);
            MuxMDR_Sel = (kind_q == K_LOAD);
            cnt_d      = '0;
            state_d    = S_RELEASE;
         end
         S_RELEASE: begin
            cnt_d = cnt_inc;
            if (!MOC) begin
               state_d = S_DONE;
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt_q == TMO_LAST) begin
               state_d = S_ERR;
               err_d   = 1'b1;
            end
`endif
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
`ifdef MEM_TIMEOUT_EN
         S_ERR: begin
            state_d = S_DONE;
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign state_out = state_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: cycle-by-cycle expected output vectors.
// Define MEM_TIMEOUT_EN on both RTL and bench to exercise the timeout path.
module tb_mem_access_seq;

   logic       Clk;
   logic       Clr;
   logic       req;
   logic [1:0] kind;
   logic       MOC;
   logic       busy, done, err;
   logic       MuxMAR_Sel, MAR_Ld, MuxMDR_Sel, MDR_Ld, IR_Ld, MOV, RW;
   logic [2:0] state_out;

   int vec_cnt  = 0;
   int fail_cnt = 0;

   mem_access_seq #(.TIMEOUT(16), .CNT_W(5)) dut (
      .Clk        (Clk),
      .Clr        (Clr),
      .req        (req),
      .kind       (kind),
      .MOC        (MOC),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .MuxMAR_Sel (MuxMAR_Sel),
      .MAR_Ld     (MAR_Ld),
      .MuxMDR_Sel (MuxMDR_Sel),
      .MDR_Ld     (MDR_Ld),
      .IR_Ld      (IR_Ld),
      .MOV        (MOV),
      .RW         (RW),
      .state_out  (state_out)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // {state, busy, done, err, MuxMAR, MAR_Ld, MuxMDR, MDR_Ld, IR_Ld, MOV, RW}
   function automatic logic [12:0] ex(input logic [2:0] st, input logic bsy, input logic dn,
                                      input logic er, input logic msel, input logic mld,
                                      input logic dsel, input logic dld, input logic ir,
                                      input logic mov, input logic rw);
      return {st, bsy, dn, er, msel, mld, dsel, dld, ir, mov, rw};
   endfunction

   function automatic logic [12:0] obs();
      return {state_out, busy, done, err, MuxMAR_Sel, MAR_Ld, MuxMDR_Sel, MDR_Ld, IR_Ld, MOV, RW};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      vec_cnt++;
      if (got !== want) begin
         fail_cnt++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Check outputs of the current state, then drive this cycle's inputs and advance.
   task automatic cyc(input string tag, input logic moc_v, input logic req_v,
                      input logic [1:0] kind_v, input logic [12:0] want);
      chk(tag, {19'd0, obs()}, {19'd0, want});
      MOC  = moc_v;
      req  = req_v;
      kind = kind_v;
      step();
   endtask

   logic [12:0] v_idle, v_addr_f, v_addr_l, v_addr_s, v_acc_r, v_acc_w;
   logic [12:0] v_cap_f, v_cap_l, v_cap_s, v_rel, v_done, v_rst;

   initial begin
      v_idle   = ex(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      v_rst    = v_idle;
      v_addr_f = ex(3'd1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
      v_addr_l = ex(3'd1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1);
      v_addr_s = ex(3'd1, 1, 0, 0, 1, 1, 0, 1, 0, 0, 1);
      v_acc_r  = ex(3'd2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      v_acc_w  = ex(3'd2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      v_cap_f  = ex(3'd3, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
      v_cap_l  = ex(3'd3, 1, 0, 0, 0, 0, 1, 1, 0, 1, 1);
      v_cap_s  = ex(3'd3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      v_rel    = ex(3'd4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      v_done   = ex(3'd5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);

      Clr  = 1'b1;
      req  = 1'b0;
      kind = 2'b00;
      MOC  = 1'b0;
      #2 Clr = 1'b0;
      #1 chk("reset_async", {19'd0, obs()}, {19'd0, v_rst});
      step();
      step();
      chk("reset_hold", {19'd0, obs()}, {19'd0, v_rst});
      Clr = 1'b1;

      // Fetch: MOC rises on the 3rd ACCESS cycle, falls on the 2nd RELEASE cycle.
      cyc("f_idle",  0, 1, 2'b00, v_idle);
      cyc("f_addr",  0, 0, 2'b00, v_addr_f);
      cyc("f_acc1",  0, 0, 2'b00, v_acc_r);
      cyc("f_acc2",  0, 0, 2'b00, v_acc_r);
      cyc("f_acc3",  1, 0, 2'b00, v_acc_r);
      cyc("f_cap",   1, 0, 2'b00, v_cap_f);
      cyc("f_rel1",  1, 0, 2'b00, v_rel);
      cyc("f_rel2",  0, 0, 2'b00, v_rel);
      cyc("f_done",  0, 0, 2'b00, v_done);
      cyc("f_idle2", 0, 0, 2'b00, v_idle);

      // Load: MOC follows MOV one cycle late.
      cyc("l_idle",  0, 1, 2'b01, v_idle);
      cyc("l_addr",  0, 0, 2'b01, v_addr_l);
      cyc("l_acc1",  0, 0, 2'b01, v_acc_r);
      cyc("l_acc2",  1, 0, 2'b01, v_acc_r);
      cyc("l_cap",   1, 0, 2'b01, v_cap_l);
      cyc("l_rel1",  1, 0, 2'b01, v_rel);
      cyc("l_rel2",  0, 0, 2'b01, v_rel);
      cyc("l_done",  0, 0, 2'b01, v_done);
      cyc("l_idle2", 0, 0, 2'b01, v_idle);

      // Store at minimum latency; kind flips to fetch while busy and must be ignored.
      cyc("s_idle",  0, 1, 2'b10, v_idle);
      cyc("s_addr",  1, 0, 2'b00, v_addr_s);
      cyc("s_acc",   1, 0, 2'b00, v_acc_w);
      cyc("s_cap",   0, 0, 2'b00, v_cap_s);
      cyc("s_rel",   0, 0, 2'b00, v_rel);
      cyc("s_done",  0, 0, 2'b00, v_done);
      cyc("s_idle2", 0, 0, 2'b00, v_idle);

      // Illegal kind held with req for three cycles.
      cyc("x_ill0",  0, 1, 2'b11, v_idle);
      cyc("x_ill1",  0, 1, 2'b11, v_idle);
      cyc("x_ill2",  0, 1, 2'b11, v_idle);
      cyc("x_idle",  0, 0, 2'b00, v_idle);

      // req held high throughout: not taken in DONE, taken on the following IDLE.
      cyc("b_idle",  0, 1, 2'b00, v_idle);
      cyc("b_addr",  1, 1, 2'b00, v_addr_f);
      cyc("b_acc",   1, 1, 2'b00, v_acc_r);
      cyc("b_cap",   0, 1, 2'b00, v_cap_f);
      cyc("b_rel",   0, 1, 2'b00, v_rel);
      cyc("b_done",  0, 1, 2'b00, v_done);
      cyc("b_idle2", 0, 1, 2'b00, v_idle);
      cyc("b_addr2", 0, 0, 2'b00, v_addr_f);

      // Asynchronous clear in the middle of ACCESS.
      chk("c_pre", {19'd0, obs()}, {19'd0, v_acc_r});
      Clr = 1'b0;
      #1 chk("c_async", {19'd0, obs()}, {19'd0, v_rst});
      step();
      chk("c_hold", {19'd0, obs()}, {19'd0, v_rst});
      Clr = 1'b1;
      cyc("c_idle",  0, 1, 2'b00, v_idle);
      cyc("c_addr",  1, 0, 2'b00, v_addr_f);
      cyc("c_acc",   1, 0, 2'b00, v_acc_r);
      cyc("c_cap",   0, 0, 2'b00, v_cap_f);
      cyc("c_rel",   0, 0, 2'b00, v_rel);
      cyc("c_done",  0, 0, 2'b00, v_done);
      cyc("c_idle2", 0, 0, 2'b00, v_idle);

`ifdef MEM_TIMEOUT_EN
      // MOC never rises: 16 ACCESS cycles, then ERR, DONE, sticky err.
      cyc("t_idle", 0, 1, 2'b00, v_idle);
      cyc("t_addr", 0, 0, 2'b00, v_addr_f);
      for (int i = 0; i < 16; i++) begin
         cyc($sformatf("t_acc%0d", i), 0, 0, 2'b00, v_acc_r);
      end
      cyc("t_err",   0, 0, 2'b00, ex(3'd6, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1));
      cyc("t_done",  0, 0, 2'b00, ex(3'd5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1));
      cyc("t_idle2", 0, 1, 2'b00, ex(3'd0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
      cyc("t_addr2", 1, 0, 2'b00, v_addr_f);
      cyc("t_acc",   1, 0, 2'b00, v_acc_r);
      cyc("t_cap",   0, 0, 2'b00, v_cap_f);
      cyc("t_rel",   0, 0, 2'b00, v_rel);
      cyc("t_done2", 0, 0, 2'b00, v_done);
      cyc("t_idle3", 0, 0, 2'b00, v_idle);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
      $finish;
   end

endmodule
